// File: rtl/pipe_pkg.sv
// Types and constants shared by the MEM stage and the hazard unit.
package pipe_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // EX/MEM branch condition flags plus the CBZ/CBNZ/B control bits.
    typedef struct packed {
        logic uncond;
        logic branch;
        logic not_zero;
        logic zero;
    } br_flags_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response handshake between the MEM stage and memory.
interface mem_access_stage_if
    import pipe_pkg::*;
#(
    parameter int XLEN = pipe_pkg::XLEN
);

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_access_stage_branch_resolve.sv
// Combinational branch decision and redirect target; shared with the hazard unit.
module branch_resolve
    import pipe_pkg::*;
#(
    parameter int XLEN = pipe_pkg::XLEN
)(
    input  br_flags_t       flags,
    input  logic            Branchreg,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] read_data_1_in,
    output logic            taken,
    output logic [XLEN-1:0] target
);

    always_comb begin
        taken = flags.uncond
              | Branchreg
              | (flags.branch & flags.zero)
              | (flags.not_zero & ~flags.zero);
        target = Branchreg ? read_data_1_in : pc_in;
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: branch resolution, 64-bit load/store over a req/ready
// handshake with upstream stall, and the MEM/WB pipeline register.
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int XLEN        = pipe_pkg::XLEN,
    parameter bit CHECK_ALIGN = 1'b1
)(
    input  logic             clock,
    input  logic             reset,

    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  read_data_1_in,
    input  logic [XLEN-1:0]  alu_result_in,
    input  logic [XLEN-1:0]  read_data_2_in,
    input  logic [REG_W-1:0] write_register_in,
    input  logic             zero_in,
    input  logic             not_zero,
    input  logic             Branch,
    input  logic             Uncondbranch,
    input  logic             Branchreg,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             MemtoReg,
    input  logic             RegWrite_in,

    mem_access_stage_if.master dmem,

    output logic             stall,
    output logic             pc_src,
    output logic [XLEN-1:0]  branch_target,
    output logic             align_fault,

    output logic [XLEN-1:0]  wb_read_data,
    output logic [XLEN-1:0]  wb_alu_result,
    output logic [REG_W-1:0] wb_write_register,
    output logic             wb_RegWrite,
    output logic             wb_MemtoReg
);

    typedef struct packed {
        logic             we;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  wdata;
        logic [REG_W-1:0] wr_reg;
        logic             reg_write;
        logic             mem_to_reg;
    } req_t;

    typedef struct packed {
        logic [XLEN-1:0]  read_data;
        logic [XLEN-1:0]  alu_result;
        logic [REG_W-1:0] wr_reg;
        logic             reg_write;
        logic             mem_to_reg;
    } wb_t;

    mem_state_t state_q, state_d;
    req_t       req_q, req_d;
    wb_t        wb_q, wb_d;

    br_flags_t  flags;
    logic       taken;
    logic       mem_op;
    logic       misaligned;
    logic       in_idle;
    logic       in_busy;
    logic       accept;
    logic       complete;

    assign flags = '{uncond:   Uncondbranch,
                     branch:   Branch,
                     not_zero: not_zero,
                     zero:     zero_in};

    branch_resolve #(.XLEN(XLEN)) u_branch (
        .flags          (flags),
        .Branchreg      (Branchreg),
        .pc_in          (pc_in),
        .read_data_1_in (read_data_1_in),
        .taken          (taken),
        .target         (branch_target)
    );

    assign mem_op     = MemRead | MemWrite;
    assign misaligned = CHECK_ALIGN & mem_op & (alu_result_in[2:0] != 3'b000);
    assign in_idle    = (state_q == IDLE);
    assign in_busy    = (state_q == BUSY);
    assign accept     = in_idle & mem_op & ~misaligned;
    assign complete   = in_busy & dmem.dmem_ready;

    // EX/MEM holds while a request is being accepted or is still in flight;
    // it advances on the same edge that completes the access.
    assign stall       = accept | (in_busy & ~dmem.dmem_ready);
    assign pc_src      = taken & ~stall;
    assign align_fault = in_idle & misaligned;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wb_d    = wb_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // MemWrite wins if both controls are set.
                    req_d = '{we:         MemWrite,
                              addr:       alu_result_in,
                              wdata:      read_data_2_in,
                              wr_reg:     write_register_in,
                              reg_write:  RegWrite_in,
                              mem_to_reg: MemtoReg};
                    state_d         = BUSY;
                    wb_d.reg_write  = 1'b0;
                    wb_d.mem_to_reg = 1'b0;
                end else begin
                    // Non-memory passthrough, or a faulting access squashed to a bubble.
                    wb_d = '{read_data:  {XLEN{1'b0}},
                             alu_result: alu_result_in,
                             wr_reg:     write_register_in,
                             reg_write:  RegWrite_in & ~misaligned,
                             mem_to_reg: MemtoReg};
                end
            end

            BUSY: begin
                if (complete) begin
                    wb_d = '{read_data:  req_q.we ? {XLEN{1'b0}} : dmem.dmem_rdata,
                             alu_result: req_q.addr,
                             wr_reg:     req_q.wr_reg,
                             reg_write:  req_q.reg_write,
                             mem_to_reg: req_q.mem_to_reg};
                    state_d = IDLE;
                end else begin
                    wb_d.reg_write  = 1'b0;
                    wb_d.mem_to_reg = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wb_q    <= wb_d;
        end
    end

    assign dmem.dmem_req   = in_busy;
    assign dmem.dmem_we    = req_q.we;
    assign dmem.dmem_addr  = req_q.addr;
    assign dmem.dmem_wdata = req_q.wdata;

    assign wb_read_data      = wb_q.read_data;
    assign wb_alu_result     = wb_q.alu_result;
    assign wb_write_register = wb_q.wr_reg;
    assign wb_RegWrite       = wb_q.reg_write;
    assign wb_MemtoReg       = wb_q.mem_to_reg;

endmodule
